// File: rtl/ram_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_loader: length-framed byte stream to 32-bit RAM writes, checksum |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module ram_loader #(
  parameter logic [15:0] BASE     = 16'h0000,
  parameter int unsigned MAXWORDS = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] a_addr,
  output logic [31:0] a_d,
  output logic        a_wr,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN0 = 3'd1;
  localparam logic [2:0] S_LEN1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_SUM  = 3'd4;

  localparam logic [16:0] MAX_LEN = 17'(MAXWORDS);

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic        xfer;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_in;
  logic        oversize;
  logic        last_byte;
  logic        last_word;
  logic [1:0]  byte_cnt;
  logic [15:0] word_cnt;
  logic [23:0] asm_word;
  logic [7:0]  sum;

  assign xfer      = in_valid && in_ready;
  assign len_in    = {in_data, len_lo};
  assign oversize  = {1'b0, len_in} > MAX_LEN;
  assign last_byte = (byte_cnt == 2'd3);
  assign last_word = (word_cnt == len - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_LEN0;
      S_LEN0: if (xfer) state_nx = S_LEN1;
      S_LEN1: begin
        if (xfer) begin
          if (len_in == 16'd0) state_nx = S_SUM;
          else if (oversize)   state_nx = S_IDLE;
          else                 state_nx = S_DATA;
        end
      end
      S_DATA: if (xfer && last_byte && last_word) state_nx = S_SUM;
      S_SUM:  if (xfer) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      S_LEN0, S_LEN1, S_DATA, S_SUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Write strobe is registered off the fourth byte, so it lands in the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo   <= 8'd0;
      len      <= 16'd0;
      byte_cnt <= 2'd0;
      word_cnt <= 16'd0;
      asm_word <= 24'd0;
      sum      <= 8'd0;
      a_addr   <= BASE;
      a_d      <= 32'd0;
      a_wr     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      a_wr <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            error    <= 1'b0;
            byte_cnt <= 2'd0;
            word_cnt <= 16'd0;
            sum      <= 8'd0;
          end
        end
        S_LEN0: if (xfer) len_lo <= in_data;
        S_LEN1: begin
          if (xfer) begin
            len <= len_in;
            if (oversize) begin
              done  <= 1'b1;
              error <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            sum      <= sum + in_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_word[7:0]   <= in_data;
              2'd1: asm_word[15:8]  <= in_data;
              2'd2: asm_word[23:16] <= in_data;
              default: begin
                a_wr     <= 1'b1;
                a_addr   <= BASE + {word_cnt[13:0], 2'b00};
                a_d      <= {in_data, asm_word};
                word_cnt <= word_cnt + 16'd1;
              end
            endcase
          end
        end
        S_SUM: begin
          if (xfer) begin
            done  <= 1'b1;
            error <= (in_data != sum);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// Bench for ram_loader: two instances (BASE 0 and 0xFFFC) against a stream-level model.
module tb_ram_loader;

  localparam int MAXW = 8192;
  localparam logic [15:0] BASES [2] = '{16'h0000, 16'hFFFC};

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [7:0] in_data;
  logic in_valid;
  logic [1:0] in_ready_d, a_wr_d, busy_d, done_d, error_d;
  logic [1:0][15:0] a_addr_d;
  logic [1:0][31:0] a_d_d;

  always #5 clk = ~clk;

  ram_loader #(.BASE(16'h0000), .MAXWORDS(MAXW)) dut0 (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_d[0]), .a_addr(a_addr_d[0]), .a_d(a_d_d[0]), .a_wr(a_wr_d[0]),
    .busy(busy_d[0]), .done(done_d[0]), .error(error_d[0]));

  ram_loader #(.BASE(16'hFFFC), .MAXWORDS(MAXW)) dut1 (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_d[1]), .a_addr(a_addr_d[1]), .a_d(a_d_d[1]), .a_wr(a_wr_d[1]),
    .busy(busy_d[1]), .done(done_d[1]), .error(error_d[1]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int unit, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, unit, $time, act, exp);
    end
  endtask

  // Stream-level model: position in the frame decides what each accepted byte means.
  bit          active [2];
  int          idx    [2];
  int          nw     [2];
  logic [7:0]  lo     [2];
  logic [7:0]  sum_m  [2];
  logic [31:0] word_m [2];
  logic        e_wr   [2];
  logic        e_done [2];
  logic        e_err  [2];
  logic [15:0] e_addr [2];
  logic [31:0] e_d    [2];

  logic [15:0] wa0[$];
  logic [31:0] wd0[$];
  logic [15:0] wa1[$];
  int done_cnt0 = 0;

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      e_wr[i]   = 1'b0;
      e_done[i] = 1'b0;
      if (reset) begin
        active[i] = 1'b0;
        e_err[i]  = 1'b0;
        e_addr[i] = BASES[i];
        e_d[i]    = 32'd0;
      end else if (!active[i]) begin
        if (start) begin
          active[i] = 1'b1;
          idx[i]    = 0;
          sum_m[i]  = 8'd0;
          e_err[i]  = 1'b0;
        end
      end else if (in_valid) begin
        if (idx[i] == 0) begin
          lo[i] = in_data;
        end else if (idx[i] == 1) begin
          nw[i] = int'({in_data, lo[i]});
          if (nw[i] > MAXW) begin
            active[i] = 1'b0;
            e_done[i] = 1'b1;
            e_err[i]  = 1'b1;
          end
        end else if (idx[i] < 2 + 4 * nw[i]) begin
          int pos;
          pos = (idx[i] - 2) % 4;
          sum_m[i] = sum_m[i] + in_data;
          if (pos == 0) word_m[i] = 32'd0;
          word_m[i][8*pos +: 8] = in_data;
          if (pos == 3) begin
            e_wr[i]   = 1'b1;
            e_addr[i] = BASES[i] + 16'(4 * ((idx[i] - 2) / 4));
            e_d[i]    = word_m[i];
          end
        end else begin
          active[i] = 1'b0;
          e_done[i] = 1'b1;
          e_err[i]  = (in_data != sum_m[i]);
        end
        idx[i]++;
      end
    end
  endtask

  initial begin : compare
    forever begin
      @(posedge clk);
      model_step();
      #1;
      for (int i = 0; i < 2; i++) begin
        chk("in_ready", i, 32'(in_ready_d[i]), 32'(active[i]));
        chk("busy",     i, 32'(busy_d[i]),     32'(active[i]));
        chk("a_wr",     i, 32'(a_wr_d[i]),     32'(e_wr[i]));
        chk("done",     i, 32'(done_d[i]),     32'(e_done[i]));
        chk("error",    i, 32'(error_d[i]),    32'(e_err[i]));
        chk("a_addr",   i, 32'(a_addr_d[i]),   32'(e_addr[i]));
        chk("a_d",      i, a_d_d[i],           e_d[i]);
      end
      if (a_wr_d[0]) begin
        wa0.push_back(a_addr_d[0]);
        wd0.push_back(a_d_d[0]);
      end
      if (a_wr_d[1]) wa1.push_back(a_addr_d[1]);
      if (done_d[0]) done_cnt0++;
    end
  end

  logic [7:0] stream[$];

  task automatic clear_log();
    wa0.delete();
    wd0.delete();
    wa1.delete();
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (k - 1) @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmax, input bit noise);
    @(negedge clk);
    repeat ($urandom_range(0, gmax)) begin
      in_valid = 1'b0;
      start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic run_stream(input int gmax, input bit noise);
    do_start();
    foreach (stream[j]) send_byte(stream[j], gmax, noise);
    idle(4);
  endtask

  task automatic nominal(input logic [7:0] s, input int gmax);
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    stream.push_back(s);
    run_stream(gmax, 1'b0);
  endtask

  task automatic check_nominal_writes();
    chk("nom_wcount", 0, wa0.size(), 2);
    if (wa0.size() == 2) begin
      chk("nom_addr0", 0, 32'(wa0[0]), 32'h0000);
      chk("nom_data0", 0, wd0[0], 32'h12345678);
      chk("nom_addr1", 0, 32'(wa0[1]), 32'h0004);
      chk("nom_data1", 0, wd0[1], 32'hDEADBEEF);
    end
    chk("wrap_wcount", 1, wa1.size(), 2);
    if (wa1.size() == 2) begin
      chk("wrap_addr0", 1, 32'(wa1[0]), 32'hFFFC);
      chk("wrap_addr1", 1, 32'(wa1[1]), 32'h0000);
    end
  endtask

  initial begin : main
    int dc;
    int nwords;
    logic [7:0] s;
    logic [7:0] b;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 0, 32'(in_ready_d[0]), 0);
    chk("rst_a_addr",   1, 32'(a_addr_d[1]), 32'hFFFC);
    chk("rst_a_d",      0, a_d_d[0], 0);
    reset = 1'b0;
    idle(2);

    // Data-byte sum of the nominal frame is 0x4C.
    clear_log(); dc = done_cnt0;
    nominal(8'h4C, 0);
    check_nominal_writes();
    chk("nom_done", 0, done_cnt0 - dc, 1);
    chk("nom_error", 0, 32'(error_d[0]), 0);
    chk("nom_busy", 0, 32'(busy_d[0]), 0);

    clear_log(); dc = done_cnt0;
    nominal(8'h09, 0);
    check_nominal_writes();
    chk("badsum_done", 0, done_cnt0 - dc, 1);
    chk("badsum_error", 0, 32'(error_d[0]), 1);

    clear_log();
    nominal(8'h08, 0);
    chk("sum08_error", 0, 32'(error_d[0]), 1);

    clear_log(); dc = done_cnt0;
    stream = '{8'h00, 8'h00, 8'h00};
    run_stream(0, 1'b0);
    chk("zero_wcount", 0, wa0.size(), 0);
    chk("zero_done", 0, done_cnt0 - dc, 1);
    chk("zero_error", 0, 32'(error_d[0]), 0);

    clear_log(); dc = done_cnt0;
    stream = '{8'h01, 8'h20};
    run_stream(0, 1'b0);
    chk("over_wcount", 0, wa0.size(), 0);
    chk("over_done", 0, done_cnt0 - dc, 1);
    chk("over_error", 0, 32'(error_d[0]), 1);
    chk("over_ready", 0, 32'(in_ready_d[0]), 0);
    chk("over_busy", 0, 32'(busy_d[0]), 0);

    clear_log();
    stream = '{8'hFF, 8'hFF};
    run_stream(2, 1'b0);
    chk("ffff_error", 0, 32'(error_d[0]), 1);

    clear_log();
    nominal(8'h4C, 3);
    check_nominal_writes();
    chk("gap_error", 0, 32'(error_d[0]), 0);

    // Abort after six data bytes.
    clear_log();
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
    do_start();
    foreach (stream[j]) send_byte(stream[j], 1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(6);
    chk("abort_wcount", 0, wa0.size(), 1);
    chk("abort_busy", 0, 32'(busy_d[0]), 0);

    // Reset in the same cycle as the fourth data byte.
    clear_log();
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34};
    do_start();
    foreach (stream[j]) send_byte(stream[j], 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h12;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    idle(6);
    chk("abort4_wcount", 0, wa0.size(), 0);

    clear_log();
    nominal(8'h4C, 1);
    check_nominal_writes();
    chk("after_abort_error", 0, 32'(error_d[0]), 0);

    for (int t = 0; t < 40; t++) begin
      nwords = $urandom_range(0, 6);
      stream = '{};
      stream.push_back(8'(nwords));
      stream.push_back(8'h00);
      s = 8'h00;
      for (int k = 0; k < 4 * nwords; k++) begin
        b = 8'($urandom);
        stream.push_back(b);
        s = s + b;
      end
      if ($urandom_range(0, 3) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
      stream.push_back(s);
      run_stream($urandom_range(0, 3), 1'b1);
    end

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
